// File: rtl/mips_board_io.sv
// Board I/O front end for the mips core: debounced switches, run/single-step
// control of the core enable, and a byte-lane LED view of the latched result.
module mips_board_io #(
  parameter int NUM_SW       = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int DATA_W       = 32,
  parameter int LED_W        = 8,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_data_valid,
  output logic [NUM_SW-1:0] sw_db,
  output logic              run_en,
  output logic [LED_W-1:0]  led,
  output logic [CNT_W-1:0]  run_cnt
);

  localparam int DB_W      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int NUM_LANES = DATA_W / LED_W;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    STEP_PULSE = 2'd2,
    STEP_WAIT  = 2'd3
  } state_e;

  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] sw_db_q, sw_db_d;
  logic [DB_W-1:0]   db_cnt_q [NUM_SW];
  logic [DB_W-1:0]   db_cnt_d [NUM_SW];
  logic              step_dly_q;
  logic              step_rise_s;
  state_e            state_q, state_d;
  logic              run_en_q;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [31:0]       lane_s;
  logic [DATA_W-1:0] lane_shift_s;

  generate
    if (NUM_SW > 2) begin : g_lane
      assign lane_s = 32'(sw_db_q[NUM_SW-1:2]);
    end else begin : g_no_lane
      assign lane_s = 32'd0;
    end
  endgenerate

  assign step_rise_s  = sw_db_q[1] & ~step_dly_q;
  assign lane_shift_s = data_q >> (lane_s * 32'(LED_W));

  // Per-channel debounce: a differing level must persist DEBOUNCE_CYC cycles.
  always_comb begin
    for (int i = 0; i < NUM_SW; i++) begin
      if (sync2_q[i] == sw_db_q[i]) begin
        db_cnt_d[i] = '0;
        sw_db_d[i]  = sw_db_q[i];
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = '0;
        sw_db_d[i]  = ~sw_db_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        sw_db_d[i]  = sw_db_q[i];
      end
    end
  end

  // Run/step control; run wins over a simultaneous step edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sw_db_q[0]) begin
          state_d = RUN;
        end else if (step_rise_s) begin
          state_d = STEP_PULSE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!sw_db_q[0]) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      STEP_PULSE: state_d = STEP_WAIT;
      STEP_WAIT: begin
        if (sw_db_q[0]) begin
          state_d = RUN;
        end else if (!sw_db_q[1]) begin
          state_d = IDLE;
        end else begin
          state_d = STEP_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result latch, LED lane select and saturating run-cycle counter.
  always_comb begin
    if (cpu_data_valid) begin
      data_d = cpu_data;
    end else begin
      data_d = data_q;
    end
    if (lane_s < 32'(NUM_LANES)) begin
      led_d = lane_shift_s[LED_W-1:0];
    end else begin
      led_d = '0;
    end
    if (run_en_q && (run_cnt_q != {CNT_W{1'b1}})) begin
      run_cnt_d = run_cnt_q + CNT_W'(1);
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // All state registers; reset has priority over every update.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sw_db_q    <= '0;
      for (int i = 0; i < NUM_SW; i++) db_cnt_q[i] <= '0;
      step_dly_q <= 1'b0;
      state_q    <= IDLE;
      run_en_q   <= 1'b0;
      data_q     <= '0;
      led_q      <= '0;
      run_cnt_q  <= '0;
    end else begin
      sync1_q    <= sw_raw;
      sync2_q    <= sync1_q;
      sw_db_q    <= sw_db_d;
      for (int i = 0; i < NUM_SW; i++) db_cnt_q[i] <= db_cnt_d[i];
      step_dly_q <= sw_db_q[1];
      state_q    <= state_d;
      run_en_q   <= (state_d == RUN) || (state_d == STEP_PULSE);
      data_q     <= data_d;
      led_q      <= led_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign sw_db   = sw_db_q;
  assign run_en  = run_en_q;
  assign led     = led_q;
  assign run_cnt = run_cnt_q;

endmodule
